// File: rtl/stack_proc_pkg.sv
// Shared encodings for the stack-processor control unit: opcodes, stack/mux codes,
// sequencer states and instruction field positions.
package stack_proc_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int IMM_MSB = 11;
  localparam int IMM_LSB = 0;
  localparam int ALU_MSB = 3;
  localparam int ALU_LSB = 0;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSHI = 4'd1;
  localparam logic [3:0] OP_POP   = 4'd2;
  localparam logic [3:0] OP_ALU   = 4'd3;
  localparam logic [3:0] OP_JMP   = 4'd4;
  localparam logic [3:0] OP_JZ    = 4'd5;
  localparam logic [3:0] OP_HALT  = 4'd6;

  localparam logic [2:0] SOP_HOLD  = 3'd0;
  localparam logic [2:0] SOP_PUSH  = 3'd1;
  localparam logic [2:0] SOP_POP   = 3'd2;
  localparam logic [2:0] SOP_BINOP = 3'd3;

  localparam logic [2:0] MUX_ALU = 3'd0;
  localparam logic [2:0] MUX_IMM = 3'd1;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;

  function automatic logic [INSTR_W-1:0] sext_imm12(input logic [11:0] imm12);
    return {{(INSTR_W-12){imm12[11]}}, imm12};
  endfunction

endpackage

// File: rtl/stack_decoder.sv
// Combinational decode of the instruction register into one cycle of datapath
// control; every output is idle unless exec is high.
module stack_decoder
  import stack_proc_pkg::*;
(
  input  logic                exec,
  input  logic [INSTR_W-1:0]  ir,
  input  logic [15:0]         top_a,
  output logic [2:0]          stack_op,
  output logic [3:0]          alu_op,
  output logic [2:0]          mux_selector,
  output logic [15:0]         immediate,
  output logic                branch_taken,
  output logic                is_alu,
  output logic                is_halt,
  output logic                is_illegal
);

  logic [3:0]  opcode;
  logic [11:0] imm12;

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign imm12  = ir[IMM_MSB:IMM_LSB];

  always_comb begin
    stack_op     = SOP_HOLD;
    alu_op       = 4'd0;
    mux_selector = MUX_ALU;
    immediate    = 16'd0;
    branch_taken = 1'b0;
    is_alu       = 1'b0;
    is_halt      = 1'b0;
    is_illegal   = 1'b0;
    if (exec) begin
      // Illegal opcodes leave every control idle, including the immediate.
      if (opcode > OP_HALT) begin
        is_illegal = 1'b1;
      end else begin
        immediate = sext_imm12(imm12);
        case (opcode)
          OP_PUSHI: begin
            stack_op     = SOP_PUSH;
            mux_selector = MUX_IMM;
          end
          OP_POP: stack_op = SOP_POP;
          OP_ALU: begin
            stack_op     = SOP_BINOP;
            mux_selector = MUX_ALU;
            alu_op       = ir[ALU_MSB:ALU_LSB];
            is_alu       = 1'b1;
          end
          OP_JMP: branch_taken = 1'b1;
          OP_JZ: begin
            stack_op     = SOP_POP;
            branch_taken = (top_a == 16'd0);
          end
          OP_HALT: is_halt = 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/stack_control_unit.sv
// Fetch/execute sequencer for the stack processor. Defining OVERFLOW_TRAP_EN makes
// an ALU overflow during execute trap instead of advancing.
//
// state    | meaning
// ST_FETCH | request instruction at pc, wait for ack
// ST_EXEC  | one cycle of decoded controls, pc update
// ST_HALT  | HALT executed, idle until reset
// ST_TRAP  | illegal opcode or overflow, idle until reset
module stack_control_unit
  import stack_proc_pkg::*;
#(
  parameter int PC_W     = 12,
  parameter int RESET_PC = 0
) (
  input  logic            CLK,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  input  logic [15:0]     top_a,
  input  logic            overflow,
  output logic [2:0]      stackOP,
  output logic [3:0]      aluOP,
  output logic [2:0]      mux_selector,
  output logic [15:0]     immediate,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            trap
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  logic            exec;
  logic            branch_taken;
  logic            is_alu;
  logic            is_halt;
  logic            is_illegal;
  logic            ovf_trap;
  logic [PC_W-1:0] branch_target;

  assign exec          = (state_q == ST_EXEC);
  assign branch_target = PC_W'(ir_q[IMM_MSB:IMM_LSB]);

  stack_decoder u_decoder (
    .exec         (exec),
    .ir           (ir_q),
    .top_a        (top_a),
    .stack_op     (stackOP),
    .alu_op       (aluOP),
    .mux_selector (mux_selector),
    .immediate    (immediate),
    .branch_taken (branch_taken),
    .is_alu       (is_alu),
    .is_halt      (is_halt),
    .is_illegal   (is_illegal)
  );

`ifdef OVERFLOW_TRAP_EN
  assign ovf_trap = is_alu & overflow;
`else
  logic unused_overflow;
  assign unused_overflow = overflow | is_alu;
  assign ovf_trap        = 1'b0;
`endif

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= PC_W'(RESET_PC);
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Halting and trapping instructions keep pc on themselves.
        if (is_illegal || ovf_trap) begin
          state_d = ST_TRAP;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          pc_d    = branch_taken ? branch_target : pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Gating with reset drops the request immediately on reset assertion.
  assign imem_req  = (state_q == ST_FETCH) && reset;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halted    = (state_q == ST_HALT);
  assign trap      = (state_q == ST_TRAP);

endmodule

// File: tb/tb_stack_control_unit.sv
// Self-checking bench for stack_control_unit: directed programs plus a random
// instruction stream checked against an instruction-level reference model.
module tb_stack_control_unit;

  logic        CLK = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] top_a;
  logic        overflow;
  logic [2:0]  stackOP;
  logic [3:0]  aluOP;
  logic [2:0]  mux_selector;
  logic [15:0] immediate;
  logic [11:0] pc;
  logic        halted;
  logic        trap;

  int checks = 0;
  int failures = 0;
  int m_pc = 0;

  always #5 CLK = ~CLK;

  stack_control_unit #(.PC_W(12), .RESET_PC(0)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .top_a        (top_a),
    .overflow     (overflow),
    .stackOP      (stackOP),
    .aluOP        (aluOP),
    .mux_selector (mux_selector),
    .immediate    (immediate),
    .pc           (pc),
    .halted       (halted),
    .trap         (trap)
  );

  // Instruction-level reference: what one executed instruction must do.
  // term: 0 continue, 1 halt, 2 trap.
  function automatic void model(input logic [15:0] instr, input int cur_pc, input logic [15:0] ta,
                                input logic ov, output int sop, output int aop, output int mux,
                                output int imm, output int npc, output int term);
    int opc = int'(instr[15:12]);
    int i12 = int'(instr[11:0]);
    int simm = (i12 >= 2048) ? i12 - 4096 : i12;
    sop = 0; aop = 0; mux = 0; imm = simm & 16'hFFFF; npc = (cur_pc + 1) % 4096; term = 0;
    case (opc)
      0: ;
      1: begin sop = 1; mux = 1; end
      2: sop = 2;
      3: begin
        sop = 3; aop = int'(instr[3:0]);
`ifdef OVERFLOW_TRAP_EN
        if (ov) begin npc = cur_pc; term = 2; end
`endif
      end
      4: npc = i12;
      5: begin sop = 2; if (ta == 16'd0) npc = i12; end
      6: begin npc = cur_pc; term = 1; end
      default: begin imm = 0; npc = cur_pc; term = 2; end
    endcase
    if (ov && opc != 3) term = term;
  endfunction

  task automatic do_instr(input logic [15:0] instr, input int delay, input logic [15:0] ta, input logic ov);
    int sop, aop, mux, imm, npc, term;
    logic [11:0] addr0;
    model(instr, m_pc, ta, ov, sop, aop, mux, imm, npc, term);
    for (int k = 0; k < 20 && imem_req !== 1'b1; k++) @(negedge CLK);
    checks++;
    if (imem_req !== 1'b1) begin
      failures++; $display("FAIL fetch_req_timeout: imem_req=%b required 1", imem_req);
    end
    addr0 = imem_addr;
    checks++;
    if (imem_addr !== 12'(m_pc)) begin
      failures++; $display("FAIL fetch_addr: got %03h required %03h", imem_addr, 12'(m_pc));
    end
    for (int d = 0; d < delay; d++) begin
      imem_ack = 1'b0; imem_data = 16'($urandom);
      @(posedge CLK); @(negedge CLK);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== addr0 || stackOP !== 3'd0) begin
        failures++;
        $display("FAIL wait_stable: req=%b addr=%03h stackOP=%0d required req=1 addr=%03h stackOP=0",
                 imem_req, imem_addr, stackOP, addr0);
      end
    end
    imem_ack = 1'b1; imem_data = instr;
    @(posedge CLK); @(negedge CLK);
    imem_ack = 1'b0; imem_data = 16'($urandom);
    top_a = ta; overflow = ov;
    #1;
    checks++;
    if (stackOP !== 3'(sop) || aluOP !== 4'(aop) || mux_selector !== 3'(mux) ||
        immediate !== 16'(imm) || imem_req !== 1'b0 || pc !== 12'(m_pc)) begin
      failures++;
      $display("FAIL exec_controls[%04h]: got sop=%0d alu=%0d mux=%0d imm=%04h req=%b pc=%03h required sop=%0d alu=%0d mux=%0d imm=%04h req=0 pc=%03h",
               instr, stackOP, aluOP, mux_selector, immediate, imem_req, pc, sop, aop, mux, 16'(imm), 12'(m_pc));
    end
    @(posedge CLK); @(negedge CLK);
    top_a = 16'($urandom); overflow = 1'b0;
    checks++;
    if (term == 0) begin
      if (pc !== 12'(npc) || imem_req !== 1'b1 || trap !== 1'b0 || halted !== 1'b0 || stackOP !== 3'd0) begin
        failures++;
        $display("FAIL after_exec[%04h]: pc=%03h req=%b trap=%b halted=%b sop=%0d required pc=%03h req=1 trap=0 halted=0 sop=0",
                 instr, pc, imem_req, trap, halted, stackOP, 12'(npc));
      end
      m_pc = npc;
    end else if (term == 1) begin
      if (halted !== 1'b1 || trap !== 1'b0 || imem_req !== 1'b0 || stackOP !== 3'd0) begin
        failures++;
        $display("FAIL halt_state: halted=%b trap=%b req=%b sop=%0d required halted=1 trap=0 req=0 sop=0",
                 halted, trap, imem_req, stackOP);
      end
    end else begin
      if (trap !== 1'b1 || halted !== 1'b0 || imem_req !== 1'b0 || pc !== 12'(m_pc) || stackOP !== 3'd0) begin
        failures++;
        $display("FAIL trap_state: trap=%b halted=%b req=%b pc=%03h sop=%0d required trap=1 halted=0 req=0 pc=%03h sop=0",
                 trap, halted, imem_req, pc, stackOP, 12'(m_pc));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    m_pc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    imem_ack = 1'b1;
    @(negedge CLK); @(negedge CLK);
    checks++;
    if (pc !== 12'h000 || imem_req !== 1'b0 || halted !== 1'b0 || trap !== 1'b0 ||
        stackOP !== 3'd0 || immediate !== 16'd0) begin
      failures++;
      $display("FAIL reset_values: pc=%03h req=%b halted=%b trap=%b sop=%0d imm=%04h required pc=000 req=0 halted=0 trap=0 sop=0 imm=0000",
               pc, imem_req, halted, trap, stackOP, immediate);
    end
    imem_ack = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin
      failures++; $display("FAIL first_req: req=%b addr=%03h required req=1 addr=000", imem_req, imem_addr);
    end
    m_pc = 0;
  endtask

  task automatic test_program();
    do_reset();
    do_instr(16'h1005, 0, 16'h0000, 1'b0);
    do_instr(16'h1FFD, 0, 16'h0005, 1'b0);
    do_instr(16'h3000, 0, 16'h0002, 1'b0);
    checks++;
    if (pc !== 12'h003) begin
      failures++; $display("FAIL program_pc: got %03h required 003", pc);
    end
  endtask

  task automatic test_ack_delay();
    do_instr(16'h0000, 4, 16'h0000, 1'b0);
    do_instr(16'h3005, 2, 16'h1234, 1'b0);
  endtask

  task automatic test_jz();
    do_instr(16'h5020, 1, 16'h0000, 1'b0);
    checks++;
    if (pc !== 12'h020) begin
      failures++; $display("FAIL jz_taken_pc: got %03h required 020", pc);
    end
    do_instr(16'h5020, 0, 16'h0001, 1'b0);
    checks++;
    if (pc !== 12'h021) begin
      failures++; $display("FAIL jz_not_taken_pc: got %03h required 021", pc);
    end
  endtask

  task automatic test_trap();
    do_reset();
    for (int i = 0; i < 7; i++) do_instr(16'h0000, int'($urandom_range(0, 1)), 16'h0000, 1'b0);
    do_instr(16'hF000, 0, 16'h0000, 1'b0);
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); @(negedge CLK);
      checks++;
      if (trap !== 1'b1 || pc !== 12'h007 || imem_req !== 1'b0 || stackOP !== 3'd0) begin
        failures++;
        $display("FAIL trap_hold: trap=%b pc=%03h req=%b sop=%0d required trap=1 pc=007 req=0 sop=0",
                 trap, pc, imem_req, stackOP);
      end
    end
    imem_ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (trap !== 1'b0 || pc !== 12'h000 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL trap_async_reset: trap=%b pc=%03h req=%b required trap=0 pc=000 req=0", trap, pc, imem_req);
    end
    @(negedge CLK);
    reset = 1'b1;
    m_pc = 0;
    do_instr(16'h0000, 0, 16'h0000, 1'b0);
  endtask

  task automatic test_wrap_jmp();
    do_instr(16'h4FFF, 0, 16'h0000, 1'b0);
    do_instr(16'h0000, 0, 16'h0000, 1'b0);
    checks++;
    if (pc !== 12'h000) begin
      failures++; $display("FAIL pc_wrap: got %03h required 000", pc);
    end
    do_instr(16'h4ABC, 1, 16'h0000, 1'b0);
    checks++;
    if (pc !== 12'hABC) begin
      failures++; $display("FAIL jmp_pc: got %03h required abc", pc);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    do_instr(16'h1001, 0, 16'h0000, 1'b0);
    do_instr(16'h3002, 0, 16'h7FFF, 1'b1);
`ifdef OVERFLOW_TRAP_EN
    checks++;
    if (trap !== 1'b1 || pc !== 12'h001) begin
      failures++; $display("FAIL overflow_trap: trap=%b pc=%03h required trap=1 pc=001", trap, pc);
    end
`else
    checks++;
    if (trap !== 1'b0 || pc !== 12'h002) begin
      failures++; $display("FAIL overflow_ignored: trap=%b pc=%03h required trap=0 pc=002", trap, pc);
    end
`endif
  endtask

  task automatic test_random();
    logic [15:0] instr;
    logic [15:0] ta;
    logic        ov;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      instr = {4'($urandom_range(0, 5)), 12'($urandom)};
      ta    = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
`ifdef OVERFLOW_TRAP_EN
      ov = 1'b0;
`else
      ov = 1'($urandom);
`endif
      do_instr(instr, int'($urandom_range(0, 3)), ta, ov);
    end
    do_instr(16'h6000, 1, 16'h0000, 1'b0);
    imem_ack = 1'b1;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      failures++; $display("FAIL halt_terminal: halted=%b req=%b required halted=1 req=0", halted, imem_req);
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000; top_a = 16'h0000; overflow = 1'b0;
    test_reset();
    test_program();
    test_ack_delay();
    test_jz();
    test_wrap_jmp();
    test_trap();
    test_overflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
